dsi_burst_scheduler: RTL
========================

// Module: dsi_burst_scheduler
// PURPOSE
//  Arbitrates the single MIPI DSI HS data path between a video-line source and a command-packet source.
//  Each burst is a whole packet of 32-bit words, driven into the LP->HS sequencer as one contiguous
//  hs_en/hs_data burst. Waits until the sequencer has returned to LP-11, then enforces an LP-11 gap
//  before the next grant. Sits between the packet builders and the LP/HS delay controller.
// PARAMETERS
//  T_GAP        8     min cycles of LP-11 after sequencer returns to LP-11, before next burst
//  DRAIN_TO     1023  max cycles in DRAIN before abort (counter 10 bits)
//  MAX_VID_RUN  4     consecutive video grants after which a pending command wins
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous active-low reset
//  vid_req      in   1   video packet ready (level)
//  vid_len      in   8   video packet length in words, 1..255; sampled at grant
//  vid_data     in   32  video word, first-word-fall-through
//  vid_rd       out  1   pop one video word (this cycle's vid_data consumed)
//  vid_grant    out  1   1-cycle pulse: video packet accepted
//  cmd_req/cmd_len/cmd_data/cmd_rd/cmd_grant  same as vid_*, for command packets
//  hs_en        out  1   burst enable to LP->HS sequencer
//  hs_data      out  32  burst word to LP->HS sequencer
//  hs_out_en    in   1   sequencer HS-active indication
//  lp_data_hs   in   2   sequencer LP line state (2'b11 = LP-11)
//  busy         out  1   high whenever state != IDLE
//  done         out  1   1-cycle pulse at GAP->IDLE
//  err_len0     out  1   1-cycle pulse: granted request had len==0
//  err_timeout  out  1   1-cycle pulse: DRAIN timed out
// BEHAVIOUR
//  Clock/reset: Single clock clk. Reset is synchronous and active-low on rst_n.
//  Reset state: All outputs are 0, hs_data is 0, the FSM is in IDLE, and vid_run is 0. Reset mid-burst
//   aborts immediately with no further rd pulses.
//  FSM states: IDLE -> SEND -> DRAIN -> GAP -> IDLE.
//  IDLE:
//   - Arbitration when both requests are pending: video wins, unless vid_run >= MAX_VID_RUN, in which
//     case command wins.
//   - Single request pending: it wins.
//   - On a win: pulse the matching *_grant and latch len into word_cnt.
//   - Winner len==0: pulse err_len0 in the same cycle and go to GAP (nothing is sent).
//   - Otherwise go to SEND.
//   - vid_run: increments (saturating at 255) on each video grant; clears on each command grant.
//  SEND:
//   - Every cycle, assert the winner's *_rd and decrement word_cnt; exit to DRAIN when word_cnt hits 1.
//   - SEND lasts exactly len cycles. Source must hold data valid throughout; no backpressure.
//   - hs_en and hs_data are registered: the word popped in cycle N appears with hs_en=1 in cycle N+1.
//   - Result: hs_en is high for exactly len consecutive cycles, 1-cycle latency.
//   - Requests arriving during SEND/DRAIN/GAP are not sampled until IDLE.
//  DRAIN:
//   - hs_en=0 and hs_data=0.
//   - Set sticky seen_hs when hs_out_en=1.
//   - Exit to GAP when seen_hs && !hs_out_en && lp_data_hs==2'b11.
//   - If the DRAIN cycle count reaches DRAIN_TO first: pulse err_timeout and go to GAP.
//  GAP: Count T_GAP cycles, then pulse done and go to IDLE. This guarantees hs_en is low for at least
//   T_GAP+1 cycles between bursts, so the sequencer's edge detector always sees a rising edge.
//  Requester rule: deassert req in the cycle after grant unless another packet is ready. req still
//   high in IDLE is treated as a new packet.
// TESTING
//  1. Video only, vid_len=4, sequencer model returns LP-11 10 cycles after hs_en falls.
//     -> Expect: 1 vid_grant, 4 vid_rd pulses, hs_en high for 4 cycles carrying D0..D3 in order,
//        done pulses T_GAP cycles after LP-11.
//  2. Both requesting continuously, len=2.
//     -> Expect grant order V,V,V,V,C,V,V,V,V,C; vid_run resets after each C.
//  3. cmd_len=0 -> Expect: cmd_grant and err_len0 in the same cycle, no cmd_rd, no hs_en,
//     done after T_GAP cycles.
//  4. Sequencer model never raises hs_out_en -> Expect err_timeout exactly DRAIN_TO cycles after
//     DRAIN entry, then GAP, done, and the next grant proceeds normally.
//  5. rst_n=0 on the 3rd cycle of a vid_len=8 burst -> Expect outputs 0 in the next cycle, busy=0,
//     and the following request is granted cleanly with vid_run restarted from 0.
//  6. Back-to-back video len=1 -> Expect: hs_en low for >= T_GAP+1 cycles between pulses, and every
//     burst sees a new hs_out_en rise.

Source files
------------

// File: rtl/dsi_burst_scheduler.sv
// dsi_burst_scheduler: arbitrates the single DSI HS data path between a video-line
// source and a command-packet source. Each grant streams one whole packet as a
// contiguous hs_en/hs_data burst, waits for the LP->HS sequencer to return to LP-11,
// then holds an LP-11 gap before the next grant.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   vid_req/len/data        video packet request, length (words), FWFT data
//   vid_rd, vid_grant       video word pop, packet-accepted pulse
//   cmd_req/len/data        command packet request, length (words), FWFT data
//   cmd_rd, cmd_grant       command word pop, packet-accepted pulse
//   hs_en, hs_data          burst enable / word to the LP->HS sequencer
//   hs_out_en, lp_data_hs   sequencer HS-active flag and LP line state
//   busy                    scheduler not idle
//   done                    pulse when the inter-burst gap completes
//   err_len0, err_timeout   zero-length grant / drain timeout pulses
module dsi_burst_scheduler #(
  parameter int unsigned T_GAP       = 8,
  parameter int unsigned DRAIN_TO    = 1023,
  parameter int unsigned MAX_VID_RUN = 4,
  localparam int unsigned LEN_W      = 8,
  localparam int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [LEN_W-1:0]  vid_len,
  input  logic [DATA_W-1:0] vid_data,
  output logic              vid_rd,
  output logic              vid_grant,
  input  logic              cmd_req,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_rd,
  output logic              cmd_grant,
  output logic              hs_en,
  output logic [DATA_W-1:0] hs_data,
  input  logic              hs_out_en,
  input  logic [1:0]        lp_data_hs,
  output logic              busy,
  output logic              done,
  output logic              err_len0,
  output logic              err_timeout
);

  localparam int unsigned DRAIN_W = 10;
  localparam int unsigned RUN_W   = 8;
  localparam int unsigned GAP_W   = (T_GAP > 1) ? $clog2(T_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sel_cmd_q, sel_cmd_d;
  logic [LEN_W-1:0]   word_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               seen_hs_q;
  logic [RUN_W-1:0]   vid_run_q;

  logic               vid_win, cmd_win;
  logic [LEN_W-1:0]   len_win;
  logic               drain_tmo, gap_end;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and arbitration decode
  always_comb begin
    state_d   = state_q;
    sel_cmd_d = sel_cmd_q;
    vid_win   = 1'b0;
    cmd_win   = 1'b0;
    len_win   = '0;
    drain_tmo = 1'b0;
    gap_end   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Video normally wins; a pending command wins once video has run MAX_VID_RUN times.
        if (vid_req && !(cmd_req && (vid_run_q >= RUN_W'(MAX_VID_RUN)))) vid_win = 1'b1;
        else if (cmd_req)                                               cmd_win = 1'b1;
        len_win = cmd_win ? cmd_len : vid_len;
        if (vid_win || cmd_win) begin
          sel_cmd_d = cmd_win;
          state_d   = (len_win == '0) ? S_GAP : S_SEND;
        end
      end
      S_SEND: begin
        if (word_cnt_q == LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (seen_hs_q && !hs_out_en && (lp_data_hs == 2'b11)) begin
          state_d = S_GAP;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_TO - 1)) begin
          drain_tmo = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(T_GAP - 1)) begin
          gap_end = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_cmd_q   <= 1'b0;
      word_cnt_q  <= '0;
      drain_cnt_q <= '0;
      gap_cnt_q   <= '0;
      seen_hs_q   <= 1'b0;
      vid_run_q   <= '0;
      vid_rd      <= 1'b0;
      cmd_rd      <= 1'b0;
      vid_grant   <= 1'b0;
      cmd_grant   <= 1'b0;
      hs_en       <= 1'b0;
      hs_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_len0    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      sel_cmd_q   <= sel_cmd_d;
      vid_grant   <= vid_win;
      cmd_grant   <= cmd_win;
      err_len0    <= (vid_win || cmd_win) && (len_win == '0);
      err_timeout <= drain_tmo;
      done        <= gap_end;
      busy        <= (state_d != S_IDLE);

      // rd is high for every SEND cycle; the popped word is re-registered onto hs_data
      vid_rd  <= (state_d == S_SEND) && !sel_cmd_d;
      cmd_rd  <= (state_d == S_SEND) &&  sel_cmd_d;
      hs_en   <= vid_rd || cmd_rd;
      if (vid_rd)      hs_data <= vid_data;
      else if (cmd_rd) hs_data <= cmd_data;
      else             hs_data <= '0;

      if (vid_win || cmd_win)    word_cnt_q <= len_win;
      else if (state_q == S_SEND) word_cnt_q <= word_cnt_q - LEN_W'(1);

      drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + DRAIN_W'(1) : '0;
      seen_hs_q   <= (state_q == S_DRAIN) ? (seen_hs_q || hs_out_en) : 1'b0;
      gap_cnt_q   <= (state_q == S_GAP)   ? gap_cnt_q + GAP_W'(1)     : '0;

      // Saturating count of consecutive video grants
      if (cmd_win)                          vid_run_q <= '0;
      else if (vid_win && vid_run_q != '1) vid_run_q <= vid_run_q + RUN_W'(1);
    end
  end

endmodule
